// File: rtl/mul_chunked_pkg.sv
// Shared types and mode encodings for the chunked iterative multiplier.
package mul_chunked_pkg;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_CALC = 1'b1
  } mul_chunk_state_e;

  localparam logic [1:0] MUL_MODE_UU = 2'b00;
  localparam logic [1:0] MUL_MODE_SU = 2'b01;
  localparam logic [1:0] MUL_MODE_SS = 2'b11;

endpackage

// File: rtl/mul_chunked_partial_product.sv
// Combinational signed (XLEN+1) x (CHUNK+1) multiply producing one partial product.
module mul_partial_product
  import mul_chunked_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 16
) (
  input  logic signed [XLEN:0]         a_i,
  input  logic signed [CHUNK:0]        d_i,
  output logic signed [XLEN+CHUNK+1:0] p_o
);

  localparam int PW = XLEN + CHUNK + 2;

  logic signed [PW-1:0] a_ext_s;
  logic signed [PW-1:0] d_ext_s;

  assign a_ext_s = {{(CHUNK + 1){a_i[XLEN]}}, a_i};
  assign d_ext_s = {{(XLEN + 1){d_i[CHUNK]}}, d_i};
  assign p_o     = a_ext_s * d_ext_s;

endmodule

// File: rtl/mul_chunked.sv
// Iterative XLEN x XLEN multiplier consuming one CHUNK-bit digit of B per cycle.
// Optional MUL_EARLY_OUT_EN: zero operands finish in a single cycle from idle.
module mul_chunked
  import mul_chunked_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CHUNK = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            stall,
  input  logic            enable_i,
  input  logic [XLEN-1:0] first_operand_i,
  input  logic [XLEN-1:0] second_operand_i,
  input  logic [1:0]      signed_mode_i,
  input  logic            mul_low_i,
  output logic            hold_o,
  output logic [XLEN-1:0] result_o
);

  localparam int N   = XLEN / CHUNK;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int PW  = XLEN + CHUNK + 2;
  localparam int EW  = PW + 2 * XLEN;
  localparam int SW  = $clog2(EW) + 1;
  localparam int AW  = 2 * XLEN;
  localparam bit MULTI = (N > 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  mul_chunk_state_e  state_q;
  logic [CW-1:0]     cnt_q;
  logic [AW-1:0]     accum_q;

  logic [SW-1:0]          shamt_s;
  logic [CHUNK-1:0]       digit_s;
  logic                   top_s;
  logic signed [XLEN:0]   a_ext_s;
  logic signed [CHUNK:0]  d_ext_s;
  logic signed [PW-1:0]   prod_s;
  logic [AW-1:0]          pp_s;
  logic [AW-1:0]          sum_s;
  logic                   early_s;
  logic                   last_cycle_s;

  // In idle cnt_q is 0, so the same digit path yields pp_0 straight from the ports.
  assign shamt_s = SW'(cnt_q) * SW'(CHUNK);
  assign digit_s = CHUNK'(second_operand_i >> shamt_s);
  assign top_s   = (cnt_q == CNT_LAST);
  assign a_ext_s = {signed_mode_i[0] & first_operand_i[XLEN-1], first_operand_i};
  assign d_ext_s = {top_s & signed_mode_i[1] & digit_s[CHUNK-1], digit_s};

  mul_partial_product #(
    .XLEN  (XLEN),
    .CHUNK (CHUNK)
  ) u_pp (
    .a_i (a_ext_s),
    .d_i (d_ext_s),
    .p_o (prod_s)
  );

  assign pp_s  = AW'({{AW{prod_s[PW-1]}}, prod_s} << shamt_s);
  assign sum_s = accum_q + pp_s;

`ifdef MUL_EARLY_OUT_EN
  assign early_s = enable_i & (state_q == MUL_IDLE) &
                   ((first_operand_i == {XLEN{1'b0}}) | (second_operand_i == {XLEN{1'b0}}));
`else
  assign early_s = 1'b0;
`endif

  assign last_cycle_s = early_s |
                        (enable_i & (((state_q == MUL_IDLE) & ~MULTI) |
                                     ((state_q == MUL_CALC) & top_s)));

  // Handshake and result slice; both forced low while reset is asserted.
  always_comb begin
    hold_o   = 1'b0;
    result_o = {XLEN{1'b0}};
    if (!reset_n) begin
      hold_o   = 1'b0;
      result_o = {XLEN{1'b0}};
    end else begin
      hold_o = enable_i & ~last_cycle_s;
      if (last_cycle_s & ~early_s) begin
        result_o = mul_low_i ? sum_s[XLEN-1:0] : sum_s[AW-1:XLEN];
      end else begin
        result_o = {XLEN{1'b0}};
      end
    end
  end

  // Sequencer: accumulates one partial product per unstalled cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MUL_IDLE;
      cnt_q   <= {CW{1'b0}};
      accum_q <= {AW{1'b0}};
    end else if (!stall) begin
      case (state_q)
        MUL_IDLE: begin
          if (enable_i & MULTI & ~early_s) begin
            accum_q <= pp_s;
            cnt_q   <= CW'(1);
            state_q <= MUL_CALC;
          end
        end
        MUL_CALC: begin
          if (!enable_i || top_s) begin
            state_q <= MUL_IDLE;
            cnt_q   <= {CW{1'b0}};
            accum_q <= {AW{1'b0}};
          end else begin
            accum_q <= sum_s;
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= MUL_IDLE;
          cnt_q   <= {CW{1'b0}};
          accum_q <= {AW{1'b0}};
        end
      endcase
    end
  end

endmodule
